// File: rtl/gen_reg_file.sv
// gen_reg_file
//   Parametrised register bank with one synchronous byte-enabled write port
//   and two combinational read ports. Used as the integer register file in
//   the decode stage. Register 0 can be hardwired to zero.
//
// Parameters
//   WIDTH    data width, multiple of 8
//   NUM_REGS number of registers, power of two, >= 2
//   ADDR_W   log2(NUM_REGS)
//   ZERO_REG 1: register 0 reads 0 and ignores writes
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active low; clears every register
//   we       write enable
//   waddr    write register index
//   wdata    write data
//   wbe      byte-lane write enables, bit k covers wdata[8k+7:8k]
//   raddr1/2 read indices
//   rdata1/2 read data, combinational
//
// Optional feature (macro GEN_REG_FILE_BYPASS_EN)
//   When defined, a read whose index matches an active write shows the
//   merged write value in the same cycle. When undefined, reads return the
//   stored contents only.

module gen_reg_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]    raddr1,
  input  logic [ADDR_W-1:0]    raddr2,
  output logic [WIDTH-1:0]     rdata1,
  output logic [WIDTH-1:0]     rdata2
);

  localparam int LANES = WIDTH / 8;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_store
      logic [LANES-1:0] lane_en;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;

      assign lane_en = {LANES{we && (waddr == ADDR_W'(r))}} & wbe;

      // Hold path is a mux feedback per lane; the clock is never gated.
      always_comb begin
        d = q;
        for (int k = 0; k < LANES; k++) begin
          if (lane_en[k]) d[8*k +: 8] = wdata[8*k +: 8];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= d;
      end

      assign regs[r] = q;
    end
  end

  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  assign stored1 = regs[raddr1];
  assign stored2 = regs[raddr2];

`ifdef GEN_REG_FILE_BYPASS_EN
  logic             byp_ok;
  logic [WIDTH-1:0] merged;

  // No forwarding during reset or into a hardwired zero register.
  assign byp_ok = rst && we && !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    merged = regs[waddr];
    for (int k = 0; k < LANES; k++) begin
      if (wbe[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  assign rdata1 = (byp_ok && (raddr1 == waddr)) ? merged : stored1;
  assign rdata2 = (byp_ok && (raddr2 == waddr)) ? merged : stored2;
`else
  assign rdata1 = stored1;
  assign rdata2 = stored2;
`endif

endmodule
